// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers: per-stage payload widths,
// control-bit positions and the fetch reset PC.
package pipe_pkg;

   localparam int IFID_DATA_W  = 64;
   localparam int IFID_CTRL_W  = 1;
   localparam int IDEX_DATA_W  = 138;
   localparam int IDEX_CTRL_W  = 10;
   localparam int EXMEM_DATA_W = 165;
   localparam int EXMEM_CTRL_W = 10;
   localparam int MEMWB_DATA_W = 69;
   localparam int MEMWB_CTRL_W = 2;

   localparam int REGWRITE = 0;
   localparam int BNE      = 1;
   localparam int BEQ      = 2;
   localparam int ZERO     = 3;
   localparam int MEMWRITE = 4;
   localparam int MEMREAD  = 5;
   localparam int MEMTOREG = 6;
   localparam int JAL      = 7;
   localparam int J        = 8;
   localparam int JR       = 9;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   function automatic logic [1:0] entry_count(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage entry (valid + data + ctrl) updated on the falling clock edge.
// clear empties the entry and zeroes its control but keeps the data; load captures an entry.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                CTRL_W     = 1,
   parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

   // Next-state: clear wins over load; otherwise hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (clear_i) begin
         valid_d = 1'b0;
         ctrl_d  = {CTRL_W{1'b0}};
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         ctrl_d  = ctrl_i;
      end else begin
         valid_d = valid_q;
      end
   end

   // Entry register, asynchronously reset.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= RESET_DATA;
         ctrl_q  <= {CTRL_W{1'b0}};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with optional skid entry, flush-to-bubble and a saturating
// stall counter. Control bits leaving the stage are zero whenever it holds a bubble.
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = EXMEM_DATA_W,
   parameter int                CTRL_W     = EXMEM_CTRL_W,
   parameter bit                SKID       = 1'b1,
   parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}},
   parameter int                CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              m_valid_s, s_valid_s;
   logic [DATA_W-1:0] m_data_s,  s_data_s,  m_data_in_s;
   logic [CTRL_W-1:0] m_ctrl_s,  s_ctrl_s,  m_ctrl_in_s;
   logic              m_load_s,  m_clear_s, m_take_s, in_fire_s;
   logic [CNT_W-1:0]  stall_q,   stall_d;

   // With the skid entry, ready depends only on stored state so out_ready has no path to it.
   always_comb begin
      if (SKID) begin
         in_ready = !s_valid_s && !flush;
      end else begin
         in_ready = (!m_valid_s || out_ready) && !flush;
      end
   end

   assign in_fire_s = in_valid && in_ready;
   assign m_take_s  = !m_valid_s || out_ready;

   // Main entry refills from the skid entry first, then from the input.
   always_comb begin
      m_load_s    = 1'b0;
      m_clear_s   = 1'b0;
      m_data_in_s = in_data;
      m_ctrl_in_s = in_ctrl;
      if (flush) begin
         m_clear_s = 1'b1;
      end else if (m_take_s) begin
         if (s_valid_s) begin
            m_load_s    = 1'b1;
            m_data_in_s = s_data_s;
            m_ctrl_in_s = s_ctrl_s;
         end else if (in_fire_s) begin
            m_load_s = 1'b1;
         end else begin
            m_clear_s = 1'b1;
         end
      end else begin
         m_load_s = 1'b0;
      end
   end

   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RESET_DATA)) u_main (
      .clk     (clk),
      .reset   (reset),
      .load_i  (m_load_s),
      .clear_i (m_clear_s),
      .data_i  (m_data_in_s),
      .ctrl_i  (m_ctrl_in_s),
      .valid_o (m_valid_s),
      .data_o  (m_data_s),
      .ctrl_o  (m_ctrl_s)
   );

   if (SKID) begin : g_skid
      logic s_load_s, s_clear_s;
      assign s_clear_s = flush || (m_take_s && s_valid_s);
      assign s_load_s  = !m_take_s && in_fire_s;

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RESET_DATA)) u_skid (
         .clk     (clk),
         .reset   (reset),
         .load_i  (s_load_s),
         .clear_i (s_clear_s),
         .data_i  (in_data),
         .ctrl_i  (in_ctrl),
         .valid_o (s_valid_s),
         .data_o  (s_data_s),
         .ctrl_o  (s_ctrl_s)
      );
   end else begin : g_no_skid
      assign s_valid_s = 1'b0;
      assign s_data_s  = RESET_DATA;
      assign s_ctrl_s  = {CTRL_W{1'b0}};
   end

   // Stall counter: clear has priority, flush leaves it alone, increment saturates.
   always_comb begin
      if (clr_cnt) begin
         stall_d = {CNT_W{1'b0}};
      end else if (m_valid_s && !out_ready && (stall_q != CNT_MAX)) begin
         stall_d = stall_q + CNT_ONE;
      end else begin
         stall_d = stall_q;
      end
   end

   // Stall counter register.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= {CNT_W{1'b0}};
      end else begin
         stall_q <= stall_d;
      end
   end

   assign out_valid = m_valid_s;
   assign out_data  = m_data_s;
   assign out_ctrl  = m_ctrl_s & {CTRL_W{m_valid_s}};
   assign occupancy = entry_count(m_valid_s, s_valid_s);
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench: a skid and a non-skid stage share one stimulus stream; each has its own FIFO
// reference model and scoreboard checked mid-cycle (state changes on the falling edge).
module tb_pipe_stage_hs;
   import pipe_pkg::*;

   localparam int          DW   = 32;
   localparam int          CW   = 10;
   localparam int          CNTW = 4;
   localparam int          CMAX = (1 << CNTW) - 1;
   localparam logic [DW-1:0] RD = RESET_PC;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_cnt = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;

   logic            in_ready  [2];
   logic            out_valid [2];
   logic [DW-1:0]   out_data  [2];
   logic [CW-1:0]   out_ctrl  [2];
   logic [1:0]      occupancy [2];
   logic [CNTW-1:0] stall_cnt [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .RESET_DATA(RD), .CNT_W(CNTW)) u_dut_skid (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid[0]), .out_ready(out_ready),
      .out_data(out_data[0]), .out_ctrl(out_ctrl[0]), .occupancy(occupancy[0]),
      .clr_cnt(clr_cnt), .stall_cnt(stall_cnt[0])
   );

   pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .RESET_DATA(RD), .CNT_W(CNTW)) u_dut_plain (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid[1]), .out_ready(out_ready),
      .out_data(out_data[1]), .out_ctrl(out_ctrl[1]), .occupancy(occupancy[1]),
      .clr_cnt(clr_cnt), .stall_cnt(stall_cnt[1])
   );

   task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, inst, $time, act, exp);
      end
   endtask

   // Reference: a FIFO of capacity 2 (skid) or 1 (plain); state advances per falling edge.
   for (genvar g = 0; g < 2; g++) begin : g_sb
      localparam bit SK = (g == 0);
      logic [DW+CW-1:0] exp_q[$];
      int stall_m = 0;

      always @(posedge clk) begin
         bit               rdy, ofire, ifire;
         logic [DW+CW-1:0] head;
         if (!reset) begin
            exp_q.delete();
            stall_m = 0;
            chk("rst_out_valid", g, 64'(out_valid[g]), 64'd0);
            chk("rst_out_ctrl",  g, 64'(out_ctrl[g]),  64'd0);
            chk("rst_out_data",  g, 64'(out_data[g]),  64'(RD));
            chk("rst_stall_cnt", g, 64'(stall_cnt[g]), 64'd0);
            chk("rst_occupancy", g, 64'(occupancy[g]), 64'd0);
            chk("rst_in_ready",  g, 64'(in_ready[g]),  64'(!flush));
         end else begin
            rdy = !flush && (SK ? (exp_q.size() < 2) : (exp_q.size() == 0 || out_ready));
            chk("in_ready",  g, 64'(in_ready[g]),  64'(rdy));
            chk("out_valid", g, 64'(out_valid[g]), 64'(exp_q.size() != 0));
            chk("occupancy", g, 64'(occupancy[g]), 64'(exp_q.size()));
            chk("stall_cnt", g, 64'(stall_cnt[g]), 64'(stall_m));
            if (exp_q.size() != 0) begin
               head = exp_q[0];
               chk("out_data", g, 64'(out_data[g]), 64'(head[DW-1:0]));
               chk("out_ctrl", g, 64'(out_ctrl[g]), 64'(head[DW+CW-1:DW]));
            end else begin
               chk("bubble_ctrl", g, 64'(out_ctrl[g]), 64'd0);
            end
            ofire = (exp_q.size() != 0) && out_ready;
            ifire = in_valid && rdy;
            if (clr_cnt) stall_m = 0;
            else if ((exp_q.size() != 0) && !out_ready && stall_m < CMAX) stall_m++;
            if (ofire) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (ifire) exp_q.push_back({in_ctrl, in_data});
         end
      end
   end

   task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic clr);
      logic [31:0] r;
      r         = $urandom;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = r[CW-1:0];
      out_ready = ordy;
      flush     = fl;
      clr_cnt   = clr;
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r;
      #1;
      reset     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA5;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b1;
      cyc(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      // Back-to-back stream
      for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      // Three-cycle downstream stall mid-stream
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'h10 + 32'(i), !(i >= 2 && i < 5), 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      // Fill both entries, flush with input present, then next entry
      cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h23, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 32'h24, 1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      // Long stall: counter saturation, then clear during stall
      for (int i = 0; i < 20; i++) cyc(i == 0, 32'h30, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
      // Plain stage: raising out_ready admits a new entry while the old drains
      cyc(1'b1, 32'h32, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      // Randomised traffic with an asynchronous reset pulse in the middle
      for (int i = 0; i < 400; i++) begin
         if (i == 200) reset = 1'b0;
         if (i == 202) reset = 1'b1;
         r = $urandom;
         cyc(r[1:0] != 2'b00, $urandom, r[5:2] < 4'd11, r[10:6] == 5'd0, r[15:11] == 5'd0);
      end
      repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline-stage register with valid/ready handshake, optional two-entry skid buffer, flush-to-bubble, and a saturating stall counter. It is the generic replacement for the fixed-field, enable-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). The block splits the payload into a data field and a control field. Control bits are forced to zero whenever the stage holds a bubble, so downstream never sees a stale RegWrite/MemWrite/branch/jump.

## Interface
- DATA_W, 165, data payload width (EX/MEM: BranchAddress, ALUResult, ReadData1, ReadData2, JumpAddress, WriteReg).
- CTRL_W, 10, control payload width (EX/MEM: RegWrite, BNE, BEQ, Zero, MemWrite, MemRead, MemtoReg, JAL, J, JR).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- RESET_DATA, 0, value of stored data on reset.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- reset  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all stored entries at the next edge.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream data.
- in_ctrl  in  CTRL_W  upstream control.
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  stored data of the main entry.
- out_ctrl  out  CTRL_W  main-entry control, ANDed with out_valid.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- clr_cnt  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: main slot M (valid, data, ctrl). Skid slot S exists only when SKID=1.
- Handshake signals:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- in_ready:
  - SKID=1: in_ready = !S.valid & !flush.
  - SKID=0: in_ready = (!M.valid | out_ready) & !flush.
- Per edge, in priority order:
  1. flush: M.valid=0, S.valid=0, M.ctrl=0, S.ctrl=0. Data is held. in_fire cannot occur in this cycle.
  2. M empty or out_fire:
     - if S.valid: M←S, S.valid=0.
     - else if in_fire: M←in, M.valid=1.
     - else M.valid=0.
  3. M held (valid and !out_ready): if in_fire then S←in, S.valid=1. This case is only reachable with SKID=1.
- Ordering is strict FIFO. No entry is dropped or duplicated except on flush.
- stall_cnt:
  - +1 each edge with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - clr_cnt has priority over increment.
  - flush does not clear it.
- Reset values: M.valid=S.valid=0; M.data=S.data=RESET_DATA; ctrl=0; stall_cnt=0; occupancy=0.
- Output values in reset: out_valid=0, out_ctrl=0, out_data=RESET_DATA, in_ready=1 (when flush=0).

## Timing
- Latency: entry accepted at edge k appears on out_* after edge k (one edge), when M was empty or draining.
- Throughput: one entry per cycle while out_ready=1, for both SKID settings.
- SKID=1: in_ready depends only on registered state and flush, so there is no ready combinational path from out_ready. A single out_ready drop is absorbed by S. in_ready falls the cycle after S fills.
- Reset assertion mid-transfer clears state immediately (asynchronous), not at the next edge. First acceptance is at the first falling edge after deassertion.
- flush together with out_fire: the downstream transfer completes in that cycle, and the stage is empty afterwards.
- Simultaneous clr_cnt and stall: the counter becomes 0.

## Structure
- Shared package pipe_pkg holds:
  - Per-stage DATA_W/CTRL_W constants.
  - Control-bit index constants: REGWRITE=0, BNE=1, BEQ=2, ZERO=3, MEMWRITE=4, MEMREAD=5, MEMTOREG=6, JAL=7, J=8, JR=9.
  - Reset-PC constant 32'h0040_0000 used as RESET_DATA for fetch stages.
- One sub-module pipe_slot: a valid+data+ctrl register with load and clear inputs, instantiated for M and, under generate, for S.

## Test plan
- Reset with in_valid=1: out_valid=0, out_ctrl=0, out_data=RESET_DATA, stall_cnt=0. First entry 0xA5 shows on out_data one edge after reset release.
- Stream 8 entries 1..8 with out_ready=1: one out_fire per edge, values 1..8 in order, occupancy never exceeds 1.
- SKID=1, out_ready low for 3 cycles mid-stream:
  - S fills, in_ready drops the cycle after, occupancy=2.
  - stall_cnt=3.
  - Order is preserved after out_ready returns.
- flush with occupancy=2 and in_valid=1: next edge out_valid=0, out_ctrl=0, in entry not accepted. The entry presented after flush deasserts is the next output.
- CNT_W=4, hold out_ready=0 for 20 cycles: stall_cnt saturates at 15. clr_cnt=1 during stall gives 0.
- SKID=0, out_ready=0 with M full: in_ready=0. Raising out_ready gives in_ready=1 in the same cycle, and a new entry is accepted while the old one drains.
